// File: rtl/sitcp_tcp_loop_fifo_if.sv
// -----------------------------------------------------------------------------
// sitcp_tcp_loop_fifo_if
//   TCP user-side bundle between the SiTCP wrapper and sitcp_tcp_loop_fifo.
//   master : SiTCP side (drives RX_WR/RX_DATA/TX_FULL, receives the rest)
//   slave  : FIFO side
//   RX_WR    receive write strobe        RX_DATA  receive byte
//   RX_WC    receive window word         TX_FULL  TX almost-full
//   TX_WR    transmit write strobe       TX_DATA  transmit byte
// -----------------------------------------------------------------------------
interface sitcp_tcp_loop_fifo_if #(
   parameter int unsigned WC_W = 16
);
   logic            RX_WR;
   logic [7:0]      RX_DATA;
   logic [WC_W-1:0] RX_WC;
   logic            TX_FULL;
   logic            TX_WR;
   logic [7:0]      TX_DATA;

   modport master (
      output RX_WR, RX_DATA, TX_FULL,
      input  RX_WC, TX_WR, TX_DATA
   );

   modport slave (
      input  RX_WR, RX_DATA, TX_FULL,
      output RX_WC, TX_WR, TX_DATA
   );
endinterface

// File: rtl/sitcp_tcp_loop_fifo.sv
// -----------------------------------------------------------------------------
// sitcp_tcp_loop_fifo
//   Parametrised byte FIFO looping SiTCP TCP RX back to TCP TX, with a
//   counter-pattern transmit mode, sticky overflow flag and flush on close.
//   Optional build macro: LOOP_STATS_EN (enables the 32-bit TX_BYTES counter;
//   otherwise TX_BYTES is tied to zero).
//
//   Parameters: ADDR_W (log2 depth, 4..15), WC_W (RX_WC width, >= ADDR_W+1)
//   Ports:
//     CLK, RST        clock, synchronous active-high reset
//     OPEN_ACK        connection open; low flushes the FIFO
//     MODE            0 loopback / 1 counter pattern, latched on open
//     tcp             SiTCP TCP bundle (RX_WR, RX_DATA, RX_WC, TX_FULL,
//                     TX_WR, TX_DATA)
//     OVF             sticky dropped-byte flag
//     LEVEL           current occupancy
//     TX_BYTES        bytes sent this connection
// -----------------------------------------------------------------------------
module sitcp_tcp_loop_fifo #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned WC_W   = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 OPEN_ACK,
   input  logic                 MODE,
   sitcp_tcp_loop_fifo_if.slave tcp,
   output logic                 OVF,
   output logic [ADDR_W:0]      LEVEL,
   output logic [31:0]          TX_BYTES
);

   typedef enum logic {
      MODE_LOOP    = 1'b0,
      MODE_PATTERN = 1'b1
   } mode_t;

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   occ;
   logic              open_q;
   mode_t             mode_q;
   mode_t             mode_eff;
   logic [7:0]        pat_cnt;

   logic full;
   logic empty;
   logic rd_en;
   logic wr_en;
   logic drop;
   logic pat_en;

   // The open-edge cycle already runs in the freshly sampled mode, so the
   // first cycle of a connection is usable in either mode.
   always_comb begin
      mode_eff = (OPEN_ACK && !open_q) ? mode_t'(MODE) : mode_q;
      full     = occ[ADDR_W];
      empty    = (occ == '0);
      rd_en    = OPEN_ACK && (mode_eff == MODE_LOOP) && !tcp.TX_FULL && !empty;
      // A full FIFO still accepts a byte when a read frees a slot this cycle.
      wr_en    = OPEN_ACK && (mode_eff == MODE_LOOP) && tcp.RX_WR && (!full || rd_en);
      drop     = OPEN_ACK && (mode_eff == MODE_LOOP) && tcp.RX_WR && !wr_en;
      pat_en   = OPEN_ACK && (mode_eff == MODE_PATTERN) && !tcp.TX_FULL;
   end

   always_ff @(posedge CLK) begin
      if (wr_en && !RST) begin
         mem[wr_ptr] <= tcp.RX_DATA;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         OVF         <= 1'b0;
         pat_cnt     <= '0;
         tcp.TX_WR   <= 1'b0;
         tcp.TX_DATA <= '0;
         mode_q      <= MODE_LOOP;
         open_q      <= 1'b0;
      end else if (!OPEN_ACK) begin
         // Flush: everything but the mode register clears.
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         occ         <= '0;
         OVF         <= 1'b0;
         pat_cnt     <= '0;
         tcp.TX_WR   <= 1'b0;
         tcp.TX_DATA <= '0;
         open_q      <= 1'b0;
      end else begin
         open_q <= 1'b1;
         mode_q <= mode_eff;
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
         if (drop) begin
            OVF <= 1'b1;
         end
         tcp.TX_WR <= rd_en || pat_en;
         if (rd_en) begin
            tcp.TX_DATA <= mem[rd_ptr];
         end else if (pat_en) begin
            tcp.TX_DATA <= pat_cnt;
         end
         if (pat_en) begin
            pat_cnt <= pat_cnt + 1'b1;
         end
      end
   end

   assign LEVEL = occ;

   generate
      if (WC_W > ADDR_W + 1) begin : g_wc_pad
         assign tcp.RX_WC = {{(WC_W - ADDR_W - 1){1'b1}}, occ};
      end else begin : g_wc_exact
         assign tcp.RX_WC = occ;
      end
   endgenerate

`ifdef LOOP_STATS_EN
   logic [31:0] tx_bytes_q;

   always_ff @(posedge CLK) begin
      if (RST || !OPEN_ACK) begin
         tx_bytes_q <= '0;
      end else if (tcp.TX_WR) begin
         tx_bytes_q <= tx_bytes_q + 32'd1;
      end
   end

   assign TX_BYTES = tx_bytes_q;
`else
   assign TX_BYTES = '0;
`endif

endmodule

// File: tb/tb_sitcp_tcp_loop_fifo.sv
// -----------------------------------------------------------------------------
// tb_sitcp_tcp_loop_fifo
//   Self-checking bench for sitcp_tcp_loop_fifo (ADDR_W=4, WC_W=16).
//   A queue-based reference model predicts every output each cycle; directed
//   steps cover loopback, overflow, full read/write, flush, pattern mode and
//   reset, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sitcp_tcp_loop_fifo;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned WC_W   = 16;
   localparam int unsigned DEPTH  = 16;

   logic              CLK = 1'b0;
   logic              RST;
   logic              OPEN_ACK;
   logic              MODE;
   logic              OVF;
   logic [ADDR_W:0]   LEVEL;
   logic [31:0]       TX_BYTES;

   sitcp_tcp_loop_fifo_if #(.WC_W(WC_W)) tcp ();

   sitcp_tcp_loop_fifo #(.ADDR_W(ADDR_W), .WC_W(WC_W)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .OPEN_ACK (OPEN_ACK),
      .MODE     (MODE),
      .tcp      (tcp.slave),
      .OVF      (OVF),
      .LEVEL    (LEVEL),
      .TX_BYTES (TX_BYTES)
   );

   always #5 CLK = ~CLK;

   // Reference model state
   logic [7:0]  q [$];
   bit          m_ovf;
   bit          m_mode;
   bit          m_prev_open;
   bit          m_wr;
   logic [7:0]  m_data;
   logic [7:0]  m_cnt;
   logic [31:0] m_txb;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_tx = 0;
   int          first_tx_cyc = 0;
   logic [7:0]  last_tx = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] exp_txb();
`ifdef LOOP_STATS_EN
      return m_txb;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_update();
      if (RST) begin
         q.delete();
         m_ovf = 0; m_mode = 0; m_cnt = '0; m_txb = '0;
         m_wr = 0; m_data = '0; m_prev_open = 0;
      end else if (!OPEN_ACK) begin
         q.delete();
         m_ovf = 0; m_cnt = '0; m_txb = '0;
         m_wr = 0; m_data = '0; m_prev_open = 0;
      end else begin
         if (m_wr) m_txb++;
         if (!m_prev_open) m_mode = MODE;
         m_prev_open = 1;
         m_wr = 0;
         if (m_mode) begin
            if (!tcp.TX_FULL) begin
               m_wr   = 1;
               m_data = m_cnt;
               m_cnt++;
            end
         end else begin
            // pop before push: a byte written this cycle cannot leave this cycle
            if (!tcp.TX_FULL && q.size() > 0) begin
               m_data = q.pop_front();
               m_wr   = 1;
            end
            if (tcp.RX_WR) begin
               if (q.size() < DEPTH) q.push_back(tcp.RX_DATA);
               else m_ovf = 1;
            end
         end
      end
   endtask

   task automatic step();
      model_update();
      @(posedge CLK);
      cyc++;
      #1;
      if (tcp.TX_WR === 1'b1) begin
         if (n_tx == 0) first_tx_cyc = cyc;
         n_tx++;
         last_tx = tcp.TX_DATA;
      end
      check("tx_wr", {31'd0, tcp.TX_WR}, {31'd0, m_wr});
      if (m_wr) check("tx_data", {24'd0, tcp.TX_DATA}, {24'd0, m_data});
      check("level", {27'd0, LEVEL}, q.size());
      check("rx_wc", {16'd0, tcp.RX_WC}, 32'hFFE0 | q.size());
      check("ovf", {31'd0, OVF}, {31'd0, m_ovf});
      check("tx_bytes", TX_BYTES, exp_txb());
   endtask

   task automatic io(input bit rst, input bit open, input bit mode,
                     input bit wr, input logic [7:0] d, input bit full);
      RST         = rst;
      OPEN_ACK    = open;
      MODE        = mode;
      tcp.RX_WR   = wr;
      tcp.RX_DATA = d;
      tcp.TX_FULL = full;
      step();
   endtask

   initial begin
      int rx_cyc;
      int peak;

      RST = 1'b1; OPEN_ACK = 1'b0; MODE = 1'b0;
      tcp.RX_WR = 1'b0; tcp.RX_DATA = '0; tcp.TX_FULL = 1'b0;

      // Reset values
      io(1, 0, 0, 0, 8'h00, 0);
      io(1, 1, 1, 1, 8'hA5, 0);
      check("rst_tx_data", {24'd0, tcp.TX_DATA}, 32'd0);
      check("rst_rx_wc", {16'd0, tcp.RX_WC}, 32'hFFE0);
      io(0, 0, 0, 0, 8'h00, 0);

      // Basic loopback 0x00..0x0F
      n_tx = 0; peak = 0; rx_cyc = cyc;
      for (int i = 0; i < 16; i++) begin
         io(0, 1, 0, 1, 8'(i), 0);
         if (int'(LEVEL) > peak) peak = int'(LEVEL);
      end
      repeat (4) io(0, 1, 0, 0, 8'h00, 0);
      check("loop_latency", first_tx_cyc - rx_cyc, 2);
      check("loop_count", n_tx, 16);
      check("loop_peak", peak, 1);
      check("loop_last", {24'd0, last_tx}, 32'h0F);

      // Overflow: 17 bytes into a 16-byte FIFO with TX blocked
      n_tx = 0;
      for (int i = 0; i < 17; i++) io(0, 1, 0, 1, 8'($urandom), 1);
      check("ovf_level", {27'd0, LEVEL}, 32'd16);
      check("ovf_rx_wc", {16'd0, tcp.RX_WC}, 32'hFFF0);
      check("ovf_flag", {31'd0, OVF}, 32'd1);
      repeat (20) io(0, 1, 0, 0, 8'h00, 0);
      check("ovf_drain", n_tx, 16);

      // Flush and reopen
      io(0, 0, 0, 0, 8'h00, 0);
      io(0, 1, 0, 0, 8'h00, 1);
      check("reopen_ovf", {31'd0, OVF}, 32'd0);

      // Full with simultaneous read and write
      n_tx = 0;
      for (int i = 0; i < 16; i++) io(0, 1, 0, 1, 8'($urandom), 1);
      io(0, 1, 0, 1, 8'($urandom), 0);
      check("rw_full_ovf", {31'd0, OVF}, 32'd0);
      check("rw_full_level", {27'd0, LEVEL}, 32'd16);
      repeat (20) io(0, 1, 0, 0, 8'h00, 0);
      check("rw_full_drain", n_tx, 17);

      // Flush at LEVEL=5 with OVF set
      for (int i = 0; i < 17; i++) io(0, 1, 0, 1, 8'($urandom), 1);
      repeat (11) io(0, 1, 0, 0, 8'h00, 0);
      check("pre_flush_level", {27'd0, LEVEL}, 32'd5);
      n_tx = 0;
      repeat (3) io(0, 0, 0, 1'($urandom), 8'($urandom), 0);
      check("flush_no_tx", n_tx, 0);
      check("flush_level", {27'd0, LEVEL}, 32'd0);
      check("flush_ovf", {31'd0, OVF}, 32'd0);
      check("flush_tx_bytes", TX_BYTES, 32'd0);

      // Pattern mode, 300 cycles, MODE toggled after the open edge
      n_tx = 0;
      for (int i = 0; i < 300; i++)
         io(0, 1, (i == 0) ? 1'b1 : 1'($urandom), 1'($urandom), 8'($urandom), 0);
      check("pat_count", n_tx, 300);
      check("pat_last", {24'd0, last_tx}, 32'h2B);
      io(0, 1, 1'($urandom), 1, 8'($urandom), 1);
`ifdef LOOP_STATS_EN
      check("pat_tx_bytes", TX_BYTES, 32'd300);
`else
      check("pat_tx_bytes", TX_BYTES, 32'd0);
`endif

      // Reset during a loopback burst
      io(0, 0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 6; i++) io(0, 1, 0, 1, 8'($urandom), 1'($urandom));
      io(1, 1, 1, 1, 8'($urandom), 0);
      check("rst_mid_tx_wr", {31'd0, tcp.TX_WR}, 32'd0);
      check("rst_mid_tx_data", {24'd0, tcp.TX_DATA}, 32'd0);
      check("rst_mid_level", {27'd0, LEVEL}, 32'd0);
      check("rst_mid_rx_wc", {16'd0, tcp.RX_WC}, 32'hFFE0);
      for (int i = 0; i < 6; i++) io(0, 1, 0, 1, 8'($urandom), 1'($urandom));

      // Randomized traffic with occasional closes and mode changes
      for (int i = 0; i < 600; i++)
         io(0, ($urandom_range(0, 24) != 0), 1'($urandom), 1'($urandom),
            8'($urandom), ($urandom_range(0, 2) == 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
